spi_leader_core: RTL and testbench
==================================

# spi_leader_core

Parametrised SPI leader engine for the CPU-side SPI subsystem. It is the successor to the fixed 8-bit single-device leader/follower block. A CPU or bus adapter hands it one word per transaction through a valid/ready handshake. The block generates SCLK with a programmable divider, drives one of several chip selects, and shifts full-duplex frames of 1..MAX_W bits, MSB- or LSB-first, in any CPOL/CPHA mode. The received word is returned as a one-cycle pulse.

## Interface
Parameters:
- MAX_W, 16, maximum frame length in bits (2..32)
- NUM_CS, 4, number of chip-select outputs (1..8)
- DIV_W, 8, width of the clock-divider field

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- cfg_cpol  in  1  SCLK idle level
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_lsb_first  in  1  1: bit 0 shifted first
- cfg_len  in  $clog2(MAX_W+1)  frame length; 0 or >MAX_W is treated as MAX_W
- cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles
- cfg_cs_sel  in  max(1,$clog2(NUM_CS))  target device index; values ≥NUM_CS select none
- tx_valid  in  1  request a transfer
- tx_ready  out  1  engine idle; a transfer is accepted when tx_valid & tx_ready
- tx_data  in  MAX_W  word to send, right-justified (bits [len-1:0] used)
- rx_valid  out  1  one-cycle pulse; rx_data is valid
- rx_data  out  MAX_W  received word, right-justified, upper bits 0
- busy  out  1  transfer in progress (cs asserted)
- sclk  out  1  SPI clock
- mosi  out  1  serial data out
- miso  in  1  serial data in
- cs_n  out  NUM_CS  active-low chip selects, at most one low

## Operation
- Reset (rst=0): state IDLE, tx_ready=0, rx_valid=0, rx_data=0, busy=0, sclk=0, mosi=0, cs_n=all 1s, counters cleared.
- In IDLE, tx_ready=1 from the first clk after reset release. sclk follows cfg_cpol, registered one cycle. cs_n is all 1s.
- On accept, latch all cfg_* and tx_data; cfg changes mid-frame have no effect. tx_ready drops the next cycle.
- FSM IDLE → SETUP → XFER → HOLD → IDLE.
  - SETUP: the selected cs_n goes low and busy=1. If CPHA=0, the first bit is driven on mosi.
  - XFER: 2·len SCLK edges, H=cfg_div+1 cycles apart.
    - CPHA=0: sample miso on odd edges (leading); shift mosi on even edges, except after the last edge.
    - CPHA=1: shift on odd edges, sample on even edges.
  - HOLD: lasts H cycles after the last edge, then cs_n goes all high, busy=0, rx_valid=1 for 1 cycle, state returns to IDLE.
- Bit order: MSB-first sends tx_data[len-1] first and shifts received bits in from the LSB. LSB-first mirrors this; rx_data bit 0 is the first bit received.
- Divider counter is DIV_W+1 bits wide and does not wrap prematurely at cfg_div=all-ones.
- rx_valid has no backpressure: rx_data holds until the next frame completes.
- Out-of-range cfg_cs_sel: the frame runs (sclk/mosi toggle) but no cs_n goes low.
- Reset mid-frame: everything returns to reset values immediately (async). No rx_valid is issued.

## Timing
- Accept at cycle t0. cs_n goes low and mosi is valid at t0+1. Edge k (1..2·len) occurs at t0+1+k·H. cs_n rises and rx_valid pulses at t0+1+(2·len+1)·H. tx_ready=1 in the cycle after that.
- miso is captured in the same clk cycle in which the registered sclk toggles to the sample edge.
- Back-to-back: tx_valid held high yields ≥1 IDLE cycle with cs_n all high between frames.
- tx_valid asserted during reset or while busy is ignored until tx_ready=1. No data loss occurs if tx_valid is held.

## Test plan
- Mode 0, MSB-first, len=8, div=0, cs_sel=0, tx 0xA5, miso looped to mosi: rx_data=0x00A5, cs_n[0] low for 17 cycles, 16 sclk edges, idle sclk=0.
- Mode 3, len=16, div=3, tx 0x1234, slave model returns 0xBEEF: rx_data=0xBEEF, sclk idles high, half-period 4 cycles, 32 edges, 132 cycles of cs_n low.
- Modes 1 and 2, LSB-first, len=5, tx 0x13, loopback: rx_data=0x13 and first mosi bit =1; both CPHA settings produce the same rx_data.
- cfg_len=0 and cfg_len=MAX_W+3 behave as MAX_W. cfg_cs_sel=NUM_CS leaves cs_n all 1s yet still completes with an rx_valid pulse.
- Back-to-back tx_valid held with three words to cs_sel 0, 1, 3: exactly one cs_n low per frame, ≥1 idle cycle between frames, three rx_valid pulses.
- rst pulled low at edge 7 of a len-8 frame: cs_n all 1s and rx_valid=0 immediately. After release, tx_ready=1 next cycle and a fresh 0x3C loopback returns 0x3C.

Source files
------------

// File: rtl/spi_leader_core_if.sv
// Host-side bus of the SPI leader: per-frame config, tx word handshake, rx word pulse and busy.
// The core attaches through the slave modport and the host side through the master modport.
interface spi_leader_core_if #(
   parameter int MAX_W  = 16,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
);
   localparam int LEN_W = $clog2(MAX_W + 1);
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic             cfg_cpol;
   logic             cfg_cpha;
   logic             cfg_lsb_first;
   logic [LEN_W-1:0] cfg_len;
   logic [DIV_W-1:0] cfg_div;
   logic [CS_W-1:0]  cfg_cs_sel;
   logic             tx_valid;
   logic             tx_ready;
   logic [MAX_W-1:0] tx_data;
   logic             rx_valid;
   logic [MAX_W-1:0] rx_data;
   logic             busy;

   modport master (
      output cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_len, cfg_div, cfg_cs_sel,
      output tx_valid, tx_data,
      input  tx_ready, rx_valid, rx_data, busy
   );

   modport slave (
      input  cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_len, cfg_div, cfg_cs_sel,
      input  tx_valid, tx_data,
      output tx_ready, rx_valid, rx_data, busy
   );
endinterface

// File: rtl/spi_leader_core.sv
// Full-duplex SPI leader: 1..MAX_W-bit frames, any CPOL/CPHA, programmable SCLK divider, one-of-NUM_CS select.
// Frame latency (2*len+1)*(cfg_div+1)+1 cycles from accept to rx_valid; tx_ready low while busy, rx_valid has no backpressure.
module spi_leader_core #(
   parameter int MAX_W  = 16,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   spi_leader_core_if.slave  bus,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);
   localparam int LEN_W = $clog2(MAX_W + 1);
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int EW    = LEN_W + 1;
   localparam int CW    = DIV_W + 1;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
   state_t state, state_nxt;

   logic             cpha_q, lsb_q, rdy_q, rx_vld_q;
   logic [LEN_W-1:0] len_q;
   logic [DIV_W-1:0] div_q;
   logic [CS_W-1:0]  sel_q;
   logic [MAX_W-1:0] tx_sh, rx_sh, rx_dat_q;
   logic [CW-1:0]    div_cnt;
   logic [EW-1:0]    edge_cnt;

   logic              accept, tick, edge_ev, done, odd, last_edge, do_sample, do_drive;
   logic [EW-1:0]     edge_num;
   logic [LEN_W-1:0]  len_in;
   logic [MAX_W-1:0]  tx_norm;
   logic [CS_W-1:0]   sel_nxt;
   logic [NUM_CS-1:0] cs_dec;

   function automatic logic head(input logic [MAX_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[MAX_W-1];
   endfunction

   function automatic logic [MAX_W-1:0] shift_out(input logic [MAX_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   // MSB-first words are left-justified so both orders shift from a fixed end.
   assign len_in  = (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(MAX_W)) ? LEN_W'(MAX_W) : bus.cfg_len;
   assign tx_norm = bus.cfg_lsb_first ? bus.tx_data : (bus.tx_data << (LEN_W'(MAX_W) - len_in));

   assign bus.tx_ready = rdy_q;
   assign bus.rx_valid = rx_vld_q;
   assign bus.rx_data  = rx_dat_q;
   assign bus.busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // SETUP emits edge 1 when its half-period expires; XFER emits the rest.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      edge_ev   = 1'b0;
      done      = 1'b0;
      tick      = (div_cnt == {1'b0, div_q});
      edge_num  = edge_cnt + EW'(1);
      last_edge = (edge_num == {len_q, 1'b0});
      odd       = edge_num[0];
      case (state)
         IDLE: begin
            if (bus.tx_valid && rdy_q) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               edge_ev   = 1'b1;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               edge_ev = 1'b1;
               if (last_edge) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (tick) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      do_sample = edge_ev && (cpha_q ? !odd : odd);
      do_drive  = edge_ev && (cpha_q ? odd : (!odd && !last_edge));
   end

   always_comb begin
      cs_dec  = '1;
      sel_nxt = accept ? bus.cfg_cs_sel : sel_q;
      for (int i = 0; i < NUM_CS; i++)
         cs_dec[i] = !((state_nxt != IDLE) && (sel_nxt == CS_W'(i)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_q    <= 1'b0;
         rx_vld_q <= 1'b0;
         rx_dat_q <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= '1;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         len_q    <= '0;
         div_q    <= '0;
         sel_q    <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
      end else begin
         // Ready stays low through the rx_valid cycle, guaranteeing an idle gap between frames.
         rdy_q    <= (state_nxt == IDLE) && !done;
         rx_vld_q <= done;
         cs_n     <= cs_dec;

         if (state == IDLE || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + CW'(1);

         if (state == IDLE) sclk <= bus.cfg_cpol;
         else if (edge_ev)  sclk <= ~sclk;

         if (accept) begin
            cpha_q   <= bus.cfg_cpha;
            lsb_q    <= bus.cfg_lsb_first;
            len_q    <= len_in;
            div_q    <= bus.cfg_div;
            sel_q    <= bus.cfg_cs_sel;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (bus.cfg_cpha) begin
               tx_sh <= tx_norm;
            end else begin
               mosi  <= head(tx_norm, bus.cfg_lsb_first);
               tx_sh <= shift_out(tx_norm, bus.cfg_lsb_first);
            end
         end

         if (edge_ev) edge_cnt <= edge_num;

         if (do_sample)
            rx_sh <= lsb_q ? {miso, rx_sh[MAX_W-1:1]} : {rx_sh[MAX_W-2:0], miso};

         if (do_drive) begin
            mosi  <= head(tx_sh, lsb_q);
            tx_sh <= shift_out(tx_sh, lsb_q);
         end

         // LSB-first bits accumulate from the top, so right-justify on completion.
         if (done)
            rx_dat_q <= lsb_q ? (rx_sh >> (LEN_W'(MAX_W) - len_q)) : rx_sh;
      end
   end
endmodule

// File: tb/tb_spi_leader_core.sv
// Directed bench for spi_leader_core: scoreboarded rx words plus SCLK/CS timing measurements.
module tb_spi_leader_core;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_leader_core_if #(.MAX_W(16), .NUM_CS(4), .DIV_W(8)) bus ();
   spi_leader_core_if #(.MAX_W(16), .NUM_CS(3), .DIV_W(8)) bus3 ();

   logic       sclk, mosi, miso, sclk3, mosi3;
   logic [3:0] cs_n;
   logic [2:0] cs_n3;

   logic        fol_en = 1'b0;
   logic        miso_fol = 1'b0;
   logic [15:0] fol_word = 16'h0;
   logic [15:0] fol_rx = 16'h0;
   int          fol_bit = 0;

   assign miso = fol_en ? miso_fol : mosi;

   spi_leader_core #(.MAX_W(16), .NUM_CS(4), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   spi_leader_core #(.MAX_W(16), .NUM_CS(3), .DIV_W(8)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3), .sclk(sclk3), .mosi(mosi3), .miso(mosi3), .cs_n(cs_n3)
   );

   // Mode-3 follower: drives on falling (leading) edges, captures mosi on rising edges.
   always @(negedge sclk) begin
      if (fol_en && fol_bit >= 0) begin
         miso_fol = fol_word[fol_bit];
         fol_bit  = fol_bit - 1;
      end
   end
   always @(posedge sclk) begin
      if (fol_en) fol_rx = {fol_rx[14:0], mosi};
   end

   int n_pass = 0, n_total = 0, n_fail = 0;
   int cyc = 0, edges = 0, cs_low = 0, rx_cnt = 0, first_edge_cyc = 0, last_edge_cyc = 0;
   int gap = 0, min_gap = 999, frames = 0, multi = 0, cs3_low = 0, rx3_cnt = 0;
   logic        sclk_prev = 1'b0, first_mosi = 1'b0, cs_idle_prev = 1'b1;
   logic [15:0] rx3_dat = 16'h0;
   logic [15:0] sb[$];
   logic [3:0]  cs_seen[$];
   logic [15:0] b2b_w[3] = '{16'h005A, 16'h00C3, 16'h000F};
   logic [1:0]  b2b_s[3] = '{2'd0, 2'd1, 2'd3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (sclk !== sclk_prev) begin
         edges++;
         if (edges == 1) begin
            first_edge_cyc = cyc;
            first_mosi     = mosi;
         end
         last_edge_cyc = cyc;
      end
      sclk_prev = sclk;
      if (cs_n !== 4'hF) begin
         cs_low++;
         if ($countones(~cs_n) > 1) multi++;
         if (cs_idle_prev) begin
            if (frames > 0 && gap < min_gap) min_gap = gap;
            frames++;
            cs_seen.push_back(cs_n);
         end
         gap          = 0;
         cs_idle_prev = 1'b0;
      end else begin
         gap++;
         cs_idle_prev = 1'b1;
      end
      if (bus.rx_valid) begin
         rx_cnt++;
         if (sb.size() == 0) check("sb_empty_on_rx", 32'(sb.size()), 1);
         else                check("sb_rx_data", 32'(bus.rx_data), 32'(sb.pop_front()));
      end
      if (cs_n3 !== 3'b111) cs3_low++;
      if (bus3.rx_valid) begin
         rx3_cnt++;
         rx3_dat = bus3.rx_data;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      edges     = 0;
      cs_low    = 0;
      sclk_prev = sclk;
      cs_seen.delete();
   endtask

   task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb,
                          input logic [4:0] len, input logic [7:0] div, input logic [1:0] sel);
      bus.cfg_cpol      = cpol;
      bus.cfg_cpha      = cpha;
      bus.cfg_lsb_first = lsb;
      bus.cfg_len       = len;
      bus.cfg_div       = div;
      bus.cfg_cs_sel    = sel;
      step(3);
      clear_stats();
   endtask

   // Presents a word, waits for acceptance and records the expected rx word.
   task automatic send(input logic [15:0] data, input logic [15:0] exp, input logic keep);
      int t;
      t = 0;
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && t < 2000) begin
         step(1);
         t++;
      end
      check("accept_timeout", 32'(bus.tx_ready), 1);
      step(1);
      sb.push_back(exp);
      if (!keep) bus.tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int t;
      t = 0;
      while (rx_cnt < n && t < 5000) begin
         step(1);
         t++;
      end
      check("rx_timeout", 32'(rx_cnt >= n), 1);
      step(3);
   endtask

   initial begin
      int t;
      int base;
      bus.cfg_cpol = 0; bus.cfg_cpha = 0; bus.cfg_lsb_first = 0; bus.cfg_len = 5'd8;
      bus.cfg_div = 8'd0; bus.cfg_cs_sel = 2'd0; bus.tx_valid = 0; bus.tx_data = 16'h0;
      bus3.cfg_cpol = 0; bus3.cfg_cpha = 0; bus3.cfg_lsb_first = 0; bus3.cfg_len = 5'd8;
      bus3.cfg_div = 8'd0; bus3.cfg_cs_sel = 2'd3; bus3.tx_valid = 0; bus3.tx_data = 16'h0;

      step(3);
      check("rst_tx_ready", 32'(bus.tx_ready), 0);
      check("rst_rx_valid", 32'(bus.rx_valid), 0);
      check("rst_rx_data", 32'(bus.rx_data), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_mosi", 32'(mosi), 0);
      check("rst_cs_n", 32'(cs_n), 32'hF);
      rst = 1'b1;
      step(1);
      check("rdy_after_rst", 32'(bus.tx_ready), 1);

      // Mode 0, MSB-first, len 8, div 0, loopback
      set_cfg(0, 0, 0, 5'd8, 8'd0, 2'd0);
      send(16'h00A5, 16'h00A5, 0);
      wait_rx(1);
      check("m0_cs_low_cycles", 32'(cs_low), 17);
      check("m0_sclk_edges", 32'(edges), 16);
      check("m0_idle_sclk", 32'(sclk), 0);
      check("m0_cs_sel", 32'(cs_seen[0]), 32'hE);

      // Mode 3, len 16, div 3, follower returns 0xBEEF
      set_cfg(1, 1, 0, 5'd16, 8'd3, 2'd0);
      fol_word = 16'hBEEF; fol_bit = 15; fol_rx = 16'h0; fol_en = 1'b1;
      send(16'h1234, 16'hBEEF, 0);
      wait_rx(2);
      fol_en = 1'b0;
      check("m3_sclk_edges", 32'(edges), 32);
      check("m3_cs_low_cycles", 32'(cs_low), 132);
      check("m3_edge_span", 32'(last_edge_cyc - first_edge_cyc), 124);
      check("m3_idle_sclk", 32'(sclk), 1);
      check("m3_follower_rx", 32'(fol_rx), 32'h1234);

      // Modes 1 and 2, LSB-first, len 5; stray upper tx bits must be ignored
      set_cfg(0, 1, 1, 5'd5, 8'd1, 2'd1);
      send(16'hFFF3, 16'h0013, 0);
      wait_rx(3);
      check("m1_first_mosi", 32'(first_mosi), 1);
      check("m1_sclk_edges", 32'(edges), 10);
      set_cfg(1, 0, 1, 5'd5, 8'd2, 2'd2);
      send(16'h0013, 16'h0013, 0);
      wait_rx(4);
      check("m2_first_mosi", 32'(first_mosi), 1);
      check("m2_cs_low_cycles", 32'(cs_low), 33);

      // Out-of-range lengths fall back to MAX_W
      set_cfg(0, 0, 0, 5'd0, 8'd0, 2'd0);
      send(16'hC3A5, 16'hC3A5, 0);
      wait_rx(5);
      check("len0_sclk_edges", 32'(edges), 32);
      set_cfg(0, 0, 1, 5'd19, 8'd0, 2'd0);
      send(16'h5AC3, 16'h5AC3, 0);
      wait_rx(6);
      check("len19_sclk_edges", 32'(edges), 32);

      // cs_sel == NUM_CS on a 3-select core: frame runs, no select asserted
      cs3_low = 0;
      base    = rx3_cnt;
      bus3.tx_data  = 16'h0096;
      bus3.tx_valid = 1'b1;
      t = 0;
      while (!bus3.tx_ready && t < 100) begin step(1); t++; end
      step(1);
      bus3.tx_valid = 1'b0;
      t = 0;
      while (rx3_cnt == base && t < 200) begin step(1); t++; end
      check("oor_rx_pulses", 32'(rx3_cnt - base), 1);
      check("oor_rx_data", 32'(rx3_dat), 32'h0096);
      check("oor_cs_low_cycles", 32'(cs3_low), 0);

      // Back-to-back with tx_valid held; select changes mid-frame must not leak
      set_cfg(0, 0, 0, 5'd8, 8'd1, 2'd0);
      min_gap = 999;
      frames  = 0;
      for (int k = 0; k < 3; k++) begin
         bus.cfg_cs_sel = b2b_s[k];
         send(b2b_w[k], b2b_w[k], 1);
      end
      bus.tx_valid = 1'b0;
      wait_rx(9);
      check("b2b_frames", 32'(cs_seen.size()), 3);
      check("b2b_cs0", 32'(cs_seen[0]), 32'hE);
      check("b2b_cs1", 32'(cs_seen[1]), 32'hD);
      check("b2b_cs3", 32'(cs_seen[2]), 32'h7);
      check("b2b_idle_gap", 32'(min_gap >= 1), 1);

      // Reset at edge 7 of a len-8 frame
      set_cfg(0, 0, 0, 5'd8, 8'd1, 2'd0);
      send(16'h0081, 16'h0081, 0);
      t = 0;
      while (edges < 7 && t < 100) begin step(1); t++; end
      check("edge7_reached", 32'(edges), 7);
      rst = 1'b0;
      #1;
      sb.delete();
      base = rx_cnt;
      check("mid_rst_cs_n", 32'(cs_n), 32'hF);
      check("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
      check("mid_rst_rx_data", 32'(bus.rx_data), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      step(3);
      rst = 1'b1;
      step(1);
      check("mid_rst_rdy", 32'(bus.tx_ready), 1);
      check("mid_rst_no_rx", 32'(rx_cnt - base), 0);
      send(16'h003C, 16'h003C, 0);
      wait_rx(base + 1);

      check("sb_drained", 32'(sb.size()), 0);
      check("one_cs_low", 32'(multi), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
